// File: rtl/dcache_perf_monitor_if.sv
// CPU-side view of the data cache as seen by the performance monitor.
// The bench or the cache side drives it through the master modport.
// The monitor only observes it through the slave modport.
interface dcache_perf_monitor_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_MemRead;
  logic              cpu_MemWrite;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_stall;
  logic              cache_idle;
  logic              sram_dirty;

  modport master (
    output cpu_MemRead, cpu_MemWrite, cpu_addr, cpu_stall, cache_idle, sram_dirty
  );

  modport slave (
    input  cpu_MemRead, cpu_MemWrite, cpu_addr, cpu_stall, cache_idle, sram_dirty
  );
endinterface

// File: rtl/dcache_perf_monitor.sv
// D-cache event monitor.
// It classifies every CPU access as a read/write hit or miss and also counts
// write-backs and stall cycles. It tracks the longest miss latency and the
// address of the most recent miss.
module dcache_perf_monitor #(
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 32,
  parameter int LAT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  dcache_perf_monitor_if.slave cpu_if,
  output logic [CNT_W-1:0]     rd_hit_cnt_o,
  output logic [CNT_W-1:0]     rd_miss_cnt_o,
  output logic [CNT_W-1:0]     wr_hit_cnt_o,
  output logic [CNT_W-1:0]     wr_miss_cnt_o,
  output logic [CNT_W-1:0]     wb_cnt_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [LAT_W-1:0]     max_miss_lat_o,
  output logic [ADDR_W-1:0]    last_miss_addr_o,
  output logic                 miss_active_o
);

  // Counter slots, one per event class.
  localparam int IDX_RD_HIT  = 0;
  localparam int IDX_RD_MISS = 1;
  localparam int IDX_WR_HIT  = 2;
  localparam int IDX_WR_MISS = 3;
  localparam int IDX_WB      = 4;
  localparam int IDX_STALL   = 5;
  localparam int N_CNT       = 6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  cnt_q [N_CNT];
  logic [CNT_W-1:0]  cnt_d [N_CNT];
  logic [N_CNT-1:0]  event_vec;
  logic [LAT_W-1:0]  max_lat_q, max_lat_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              flag_q, flag_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic req, is_wr, miss_start, miss_cont, miss_done, hit;

  // Writes take priority when a read and a write are requested together.
  assign req        = cpu_if.cpu_MemRead | cpu_if.cpu_MemWrite;
  assign is_wr      = cpu_if.cpu_MemWrite;
  assign miss_start = cpu_if.cpu_stall & cpu_if.cache_idle & req;
  assign miss_cont  = cpu_if.cpu_stall & flag_q & ~miss_start;
  assign miss_done  = ~cpu_if.cpu_stall & flag_q;
  assign hit        = ~cpu_if.cpu_stall & ~flag_q & req;

  assign event_vec[IDX_RD_HIT]  = hit & ~is_wr;
  assign event_vec[IDX_RD_MISS] = miss_start & ~is_wr;
  assign event_vec[IDX_WR_HIT]  = hit & is_wr;
  assign event_vec[IDX_WR_MISS] = miss_start & is_wr;
  assign event_vec[IDX_WB]      = miss_start & cpu_if.sram_dirty;
  assign event_vec[IDX_STALL]   = cpu_if.cpu_stall;

  // Track the in-flight miss. This keeps running while counting is disabled
  // so that an access which completes after re-enable is classified correctly.
  always_comb begin
    flag_d = flag_q;
    lat_d  = lat_q;
    if (miss_start) begin
      flag_d = 1'b1;
      lat_d  = LAT_ONE;
    end else if (miss_cont) begin
      if (!(&lat_q)) lat_d = lat_q + LAT_ONE;
    end else if (!cpu_if.cpu_stall) begin
      flag_d = 1'b0;
      lat_d  = '0;
    end
  end

  // Next-state for the counters, max latency and last miss address.
  // A clear takes priority over, and discards, any event in the same cycle.
  always_comb begin
    for (int i = 0; i < N_CNT; i++) cnt_d[i] = cnt_q[i];
    max_lat_d   = max_lat_q;
    last_addr_d = last_addr_q;
    if (clear_i) begin
      for (int i = 0; i < N_CNT; i++) cnt_d[i] = '0;
      max_lat_d   = '0;
      last_addr_d = '0;
    end else if (enable_i) begin
      for (int i = 0; i < N_CNT; i++) begin
        if (event_vec[i]) begin
          if ((SATURATE != 0) && (&cnt_q[i])) cnt_d[i] = cnt_q[i];
          else                                 cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      if (miss_start)                   last_addr_d = cpu_if.cpu_addr;
      if (miss_done && lat_q > max_lat_q) max_lat_d = lat_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
      max_lat_q   <= '0;
      last_addr_q <= '0;
      flag_q      <= 1'b0;
      lat_q       <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++) cnt_q[i] <= cnt_d[i];
      max_lat_q   <= max_lat_d;
      last_addr_q <= last_addr_d;
      flag_q      <= flag_d;
      lat_q       <= lat_d;
    end
  end

  assign rd_hit_cnt_o     = cnt_q[IDX_RD_HIT];
  assign rd_miss_cnt_o    = cnt_q[IDX_RD_MISS];
  assign wr_hit_cnt_o     = cnt_q[IDX_WR_HIT];
  assign wr_miss_cnt_o    = cnt_q[IDX_WR_MISS];
  assign wb_cnt_o         = cnt_q[IDX_WB];
  assign stall_cnt_o      = cnt_q[IDX_STALL];
  assign max_miss_lat_o   = max_lat_q;
  assign last_miss_addr_o = last_addr_q;
  assign miss_active_o    = flag_q;

endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Directed testbench for dcache_perf_monitor.
// The main instance uses the default parameters.
// Two 4-bit-counter instances check the saturating and wrapping overflow behaviour.
module tb_dcache_perf_monitor;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic clear;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_perf_monitor_if #(.ADDR_W(32)) cpu_if ();

  logic [31:0] rd_hit, rd_miss, wr_hit, wr_miss, wb, stall_cnt;
  logic [7:0]  max_lat;
  logic [31:0] last_addr;
  logic        miss_active;

  logic [3:0]  s_rd_hit, s_rd_miss, s_wr_hit, s_wr_miss, s_wb, s_stall;
  logic [7:0]  s_max_lat;
  logic [31:0] s_last_addr;
  logic        s_active;

  logic [3:0]  w_rd_hit, w_rd_miss, w_wr_hit, w_wr_miss, w_wb, w_stall;
  logic [7:0]  w_max_lat;
  logic [31:0] w_last_addr;
  logic        w_active;

  always #5 clk = ~clk;

  dcache_perf_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .cpu_if(cpu_if.slave),
    .rd_hit_cnt_o(rd_hit), .rd_miss_cnt_o(rd_miss), .wr_hit_cnt_o(wr_hit),
    .wr_miss_cnt_o(wr_miss), .wb_cnt_o(wb), .stall_cnt_o(stall_cnt),
    .max_miss_lat_o(max_lat), .last_miss_addr_o(last_addr), .miss_active_o(miss_active)
  );

  dcache_perf_monitor #(.CNT_W(4), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .cpu_if(cpu_if.slave),
    .rd_hit_cnt_o(s_rd_hit), .rd_miss_cnt_o(s_rd_miss), .wr_hit_cnt_o(s_wr_hit),
    .wr_miss_cnt_o(s_wr_miss), .wb_cnt_o(s_wb), .stall_cnt_o(s_stall),
    .max_miss_lat_o(s_max_lat), .last_miss_addr_o(s_last_addr), .miss_active_o(s_active)
  );

  dcache_perf_monitor #(.CNT_W(4), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .cpu_if(cpu_if.slave),
    .rd_hit_cnt_o(w_rd_hit), .rd_miss_cnt_o(w_rd_miss), .wr_hit_cnt_o(w_wr_hit),
    .wr_miss_cnt_o(w_wr_miss), .wb_cnt_o(w_wb), .stall_cnt_o(w_stall),
    .max_miss_lat_o(w_max_lat), .last_miss_addr_o(w_last_addr), .miss_active_o(w_active)
  );

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cpu_if.cpu_MemRead  = 1'b0;
    cpu_if.cpu_MemWrite = 1'b0;
    cpu_if.cpu_addr     = '0;
    cpu_if.cpu_stall    = 1'b0;
    cpu_if.cache_idle   = 1'b1;
    cpu_if.sram_dirty   = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    enable = 1'b1;
    clear  = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus_idle();
    enable = 1'b1;
    clear  = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    n_tests++; if (rd_hit !== 32'd0)    begin n_fail++; $display("FAIL reset_rd_hit: got %0d expected 0", rd_hit); end
    n_tests++; if (rd_miss !== 32'd0)   begin n_fail++; $display("FAIL reset_rd_miss: got %0d expected 0", rd_miss); end
    n_tests++; if (wr_hit !== 32'd0)    begin n_fail++; $display("FAIL reset_wr_hit: got %0d expected 0", wr_hit); end
    n_tests++; if (wr_miss !== 32'd0)   begin n_fail++; $display("FAIL reset_wr_miss: got %0d expected 0", wr_miss); end
    n_tests++; if (wb !== 32'd0)        begin n_fail++; $display("FAIL reset_wb: got %0d expected 0", wb); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    n_tests++; if (max_lat !== 8'd0)    begin n_fail++; $display("FAIL reset_max_lat: got %0d expected 0", max_lat); end
    n_tests++; if (last_addr !== 32'd0) begin n_fail++; $display("FAIL reset_last_addr: got %0h expected 0", last_addr); end
    n_tests++; if (miss_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b expected 0", miss_active); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_read_miss();
    do_reset();
    cpu_if.cpu_MemRead = 1'b1;
    cpu_if.cpu_addr    = 32'h200;
    cpu_if.cpu_stall   = 1'b1;
    cpu_if.cache_idle  = 1'b1;
    tick();
    n_tests++; if (miss_active !== 1'b1) begin n_fail++; $display("FAIL rmiss_active: got %0b expected 1", miss_active); end
    n_tests++; if (rd_miss !== 32'd1)    begin n_fail++; $display("FAIL rmiss_early_cnt: got %0d expected 1", rd_miss); end
    cpu_if.cache_idle = 1'b0;
    repeat (4) tick();
    cpu_if.cpu_stall  = 1'b0;
    cpu_if.cache_idle = 1'b1;
    tick();
    n_tests++; if (rd_miss !== 32'd1)     begin n_fail++; $display("FAIL rmiss_cnt: got %0d expected 1", rd_miss); end
    n_tests++; if (rd_hit !== 32'd0)      begin n_fail++; $display("FAIL rmiss_hit: got %0d expected 0", rd_hit); end
    n_tests++; if (max_lat !== 8'd5)      begin n_fail++; $display("FAIL rmiss_max_lat: got %0d expected 5", max_lat); end
    n_tests++; if (last_addr !== 32'h200) begin n_fail++; $display("FAIL rmiss_addr: got %0h expected 200", last_addr); end
    n_tests++; if (stall_cnt !== 32'd5)   begin n_fail++; $display("FAIL rmiss_stall: got %0d expected 5", stall_cnt); end
    n_tests++; if (miss_active !== 1'b0)  begin n_fail++; $display("FAIL rmiss_done_active: got %0b expected 0", miss_active); end
    bus_idle();
    tick();
    $display("[TB] test_read_miss done");
  endtask

  task automatic test_write_miss_back_to_back();
    do_reset();
    cpu_if.cpu_MemWrite = 1'b1;
    cpu_if.cpu_addr     = 32'h400;
    cpu_if.sram_dirty   = 1'b1;
    cpu_if.cpu_stall    = 1'b1;
    cpu_if.cache_idle   = 1'b1;
    tick();
    cpu_if.cache_idle = 1'b0;
    cpu_if.sram_dirty = 1'b0;
    repeat (9) tick();
    cpu_if.cpu_stall  = 1'b0;
    cpu_if.cache_idle = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      cpu_if.cpu_addr = 32'h500 + 32'(i * 4);
      tick();
    end
    bus_idle();
    tick();
    n_tests++; if (wr_miss !== 32'd1)     begin n_fail++; $display("FAIL wmiss_cnt: got %0d expected 1", wr_miss); end
    n_tests++; if (wb !== 32'd1)          begin n_fail++; $display("FAIL wmiss_wb: got %0d expected 1", wb); end
    n_tests++; if (wr_hit !== 32'd3)      begin n_fail++; $display("FAIL wmiss_wr_hit: got %0d expected 3", wr_hit); end
    n_tests++; if (max_lat !== 8'd10)     begin n_fail++; $display("FAIL wmiss_max_lat: got %0d expected 10", max_lat); end
    n_tests++; if (last_addr !== 32'h400) begin n_fail++; $display("FAIL wmiss_addr: got %0h expected 400", last_addr); end
    n_tests++; if (stall_cnt !== 32'd10)  begin n_fail++; $display("FAIL wmiss_stall: got %0d expected 10", stall_cnt); end
    n_tests++; if (rd_miss !== 32'd0)     begin n_fail++; $display("FAIL wmiss_rd_miss: got %0d expected 0", rd_miss); end
    $display("[TB] test_write_miss_back_to_back done");
  endtask

  task automatic test_overflow();
    do_reset();
    cpu_if.cpu_MemRead = 1'b1;
    repeat (20) tick();
    bus_idle();
    tick();
    n_tests++; if (s_rd_hit !== 4'd15) begin n_fail++; $display("FAIL ovf_saturate: got %0d expected 15", s_rd_hit); end
    n_tests++; if (w_rd_hit !== 4'd4)  begin n_fail++; $display("FAIL ovf_wrap: got %0d expected 4", w_rd_hit); end
    n_tests++; if (rd_hit !== 32'd20)  begin n_fail++; $display("FAIL ovf_wide: got %0d expected 20", rd_hit); end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_clear();
    do_reset();
    cpu_if.cpu_MemRead = 1'b1;
    tick();
    cpu_if.cpu_MemRead = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cpu_if.cpu_MemRead = 1'b0;
    tick();
    n_tests++; if (rd_hit !== 32'd0) begin n_fail++; $display("FAIL clear_drop: got %0d expected 0", rd_hit); end
    cpu_if.cpu_MemRead = 1'b1;
    tick();
    cpu_if.cpu_MemRead = 1'b0;
    tick();
    n_tests++; if (rd_hit !== 32'd1) begin n_fail++; $display("FAIL clear_next_hit: got %0d expected 1", rd_hit); end
    $display("[TB] test_clear done");
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    cpu_if.cpu_MemRead = 1'b1;
    cpu_if.cpu_addr    = 32'h600;
    cpu_if.cpu_stall   = 1'b1;
    cpu_if.cache_idle  = 1'b1;
    tick();
    cpu_if.cache_idle = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if (miss_active !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_active: got %0b expected 0", miss_active); end
    n_tests++; if (rd_miss !== 32'd0)    begin n_fail++; $display("FAIL rstmid_async_miss: got %0d expected 0", rd_miss); end
    rst = 1'b0;
    cpu_if.cpu_stall  = 1'b0;
    cpu_if.cache_idle = 1'b1;
    tick();
    n_tests++; if (rd_hit !== 32'd1)      begin n_fail++; $display("FAIL rstmid_hit: got %0d expected 1", rd_hit); end
    n_tests++; if (rd_miss !== 32'd0)     begin n_fail++; $display("FAIL rstmid_miss: got %0d expected 0", rd_miss); end
    n_tests++; if (max_lat !== 8'd0)      begin n_fail++; $display("FAIL rstmid_max_lat: got %0d expected 0", max_lat); end
    n_tests++; if (miss_active !== 1'b0)  begin n_fail++; $display("FAIL rstmid_active: got %0b expected 0", miss_active); end
    bus_idle();
    tick();
    $display("[TB] test_reset_mid_miss done");
  endtask

  task automatic test_enable_mid_miss();
    do_reset();
    enable = 1'b0;
    cpu_if.cpu_MemRead = 1'b1;
    cpu_if.cpu_addr    = 32'h700;
    cpu_if.cpu_stall   = 1'b1;
    cpu_if.cache_idle  = 1'b1;
    tick();
    cpu_if.cache_idle = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    cpu_if.cpu_stall  = 1'b0;
    cpu_if.cache_idle = 1'b1;
    tick();
    bus_idle();
    tick();
    n_tests++; if (rd_hit !== 32'd0)    begin n_fail++; $display("FAIL en_hit: got %0d expected 0", rd_hit); end
    n_tests++; if (rd_miss !== 32'd0)   begin n_fail++; $display("FAIL en_miss: got %0d expected 0", rd_miss); end
    n_tests++; if (max_lat !== 8'd3)    begin n_fail++; $display("FAIL en_max_lat: got %0d expected 3", max_lat); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL en_stall: got %0d expected 0", stall_cnt); end
    n_tests++; if (last_addr !== 32'd0) begin n_fail++; $display("FAIL en_addr: got %0h expected 0", last_addr); end
    $display("[TB] test_enable_mid_miss done");
  endtask

  task automatic test_idle_stall_and_priority();
    do_reset();
    cpu_if.cpu_stall  = 1'b1;
    cpu_if.cache_idle = 1'b1;
    tick();
    bus_idle();
    n_tests++; if (stall_cnt !== 32'd1)  begin n_fail++; $display("FAIL idlestall_cnt: got %0d expected 1", stall_cnt); end
    n_tests++; if (rd_miss !== 32'd0)    begin n_fail++; $display("FAIL idlestall_miss: got %0d expected 0", rd_miss); end
    n_tests++; if (miss_active !== 1'b0) begin n_fail++; $display("FAIL idlestall_active: got %0b expected 0", miss_active); end
    cpu_if.cpu_MemRead  = 1'b1;
    cpu_if.cpu_MemWrite = 1'b1;
    tick();
    bus_idle();
    tick();
    n_tests++; if (wr_hit !== 32'd1) begin n_fail++; $display("FAIL prio_wr_hit: got %0d expected 1", wr_hit); end
    n_tests++; if (rd_hit !== 32'd0) begin n_fail++; $display("FAIL prio_rd_hit: got %0d expected 0", rd_hit); end
    $display("[TB] test_idle_stall_and_priority done");
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    clear  = 1'b0;
    bus_idle();
    test_reset();
    test_read_miss();
    test_write_miss_back_to_back();
    test_overflow();
    test_clear();
    test_reset_mid_miss();
    test_enable_mid_miss();
    test_idle_stall_and_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
